// File: rtl/std_lane_pkg.sv
// rtl/std_lane_pkg.sv - shared framing, lane-state and width definitions for the lane elastic bank
package std_lane_pkg;

  // Lane framing code carried alongside every data word
  typedef enum logic [1:0] {
    CNTL_SOD     = 2'b00,
    CNTL_MOD     = 2'b01,
    CNTL_EOD     = 2'b10,
    CNTL_SOD_EOD = 2'b11
  } cntl_e;

  // Per-lane input framing state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IN_OP = 2'd1,
    ST_DONE  = 2'd2
  } lane_state_e;

  localparam int unsigned CNTL_W        = 2;
  localparam int unsigned DEF_NUM_LANES = 32;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_DEPTH     = 8;
  localparam int unsigned DEF_CNT_W     = 16;

  // True for the two codes that open a new operation
  function automatic logic is_start(input cntl_e c);
    return (c == CNTL_SOD) || (c == CNTL_SOD_EOD);
  endfunction

endpackage

// File: rtl/std_lane_fifo.sv
// rtl/std_lane_fifo.sv - single-lane synchronous FIFO with registered occupancy
module std_lane_fifo
  import std_lane_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_DATA_W + CNTL_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (occupancy == OCC_W'(DEPTH));
  assign empty   = (occupancy == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head word is forced to zero while empty so stale storage never leaks out
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Storage array is write-only on push; it needs no reset because empty masks it
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); occupancy tracks push/pop balance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/std_lane_elastic_bank.sv
// rtl/std_lane_elastic_bank.sv - N-lane framed elastic buffer with lane masking and completion detection
module std_lane_elastic_bank
  import std_lane_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        reset_poweron_n,
  input  logic [NUM_LANES-1:0]        lane_enable,
  input  logic [NUM_LANES-1:0]        in_valid,
  input  logic [2*NUM_LANES-1:0]      in_cntl,
  input  logic [DATA_W*NUM_LANES-1:0] in_data,
  output logic [NUM_LANES-1:0]        in_ready,
  output logic [NUM_LANES-1:0]        out_valid,
  output logic [2*NUM_LANES-1:0]      out_cntl,
  output logic [DATA_W*NUM_LANES-1:0] out_data,
  input  logic [NUM_LANES-1:0]        out_ready,
  output logic                        op_complete,
  output logic [CNT_W*NUM_LANES-1:0]  op_word_count,
  output logic [NUM_LANES-1:0]        proto_err,
  input  logic                        clear_err
);

  localparam int FW    = DATA_W + CNTL_W;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [NUM_LANES-1:0] active;
  logic [NUM_LANES-1:0] lane_idle;
  logic [NUM_LANES-1:0] lane_settled;
  logic                 all_idle;
  logic                 complete_cond;

  assign all_idle = &lane_idle;

  // An operation is complete when some lane is active and every active lane has
  // seen its end-of-data and drained it downstream
  assign complete_cond = (|active) && (&lane_settled);

  // Mask only follows lane_enable between operations; completion is a one-cycle
  // registered pulse, blocked from repeating while the DONE lanes return to IDLE
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      active      <= '0;
      op_complete <= 1'b0;
    end else begin
      if (all_idle) begin
        active <= lane_enable;
      end
      op_complete <= complete_cond && !op_complete;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_state_e      state;
    cntl_e            cntl_in;
    logic [FW-1:0]    head;
    logic [OCC_W-1:0] occupancy;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             err_set;
    logic             err_q;
    logic [CNT_W-1:0] word_count;

    assign cntl_in    = cntl_e'(in_cntl[2*i +: 2]);
    assign fifo_full  = (occupancy == OCC_W'(DEPTH));
    assign fifo_empty = (occupancy == '0);

    assign in_ready[i]  = active[i] && !fifo_full && (state != ST_DONE);
    assign out_valid[i] = active[i] && !fifo_empty;
    assign push         = in_valid[i] && in_ready[i];
    assign pop          = out_valid[i] && out_ready[i];

    assign lane_idle[i]    = (state == ST_IDLE);
    assign lane_settled[i] = !active[i] || ((state == ST_DONE) && fifo_empty);

    // Framing violations: continuation/end without a start, or a start inside an operation
    assign err_set = push &&
                     (((state == ST_IDLE)  && !is_start(cntl_in)) ||
                      ((state == ST_IN_OP) &&  is_start(cntl_in)));

    std_lane_fifo #(
      .DEPTH (DEPTH),
      .W     (FW)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (reset_poweron_n),
      .push      (push),
      .push_data ({in_cntl[2*i +: 2], in_data[DATA_W*i +: DATA_W]}),
      .pop       (pop),
      .head_data (head),
      .occupancy (occupancy)
    );

    assign out_cntl[2*i +: 2]           = head[FW-1 -: CNTL_W];
    assign out_data[DATA_W*i +: DATA_W] = head[DATA_W-1:0];
    assign op_word_count[CNT_W*i +: CNT_W] = word_count;
    assign proto_err[i]                 = err_q;

    // Input framing FSM; DONE holds the lane closed until the bank-wide completion pulse
    always_ff @(posedge clk or negedge reset_poweron_n) begin
      if (!reset_poweron_n) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (push && (cntl_in == CNTL_SOD)) begin
              state <= ST_IN_OP;
            end else if (push && (cntl_in == CNTL_SOD_EOD)) begin
              state <= ST_DONE;
            end
          end
          ST_IN_OP: begin
            if (push && (cntl_in == CNTL_EOD)) begin
              state <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (op_complete) begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end

    // Sticky error; a fresh error in the clearing cycle keeps the bit set
    always_ff @(posedge clk or negedge reset_poweron_n) begin
      if (!reset_poweron_n) begin
        err_q <= 1'b0;
      end else begin
        err_q <= err_set || (err_q && !clear_err);
      end
    end

    // Accepted-word counter: restarts at 1 on a start word in IDLE, saturates at all-ones
    always_ff @(posedge clk or negedge reset_poweron_n) begin
      if (!reset_poweron_n) begin
        word_count <= '0;
      end else if (push) begin
        if ((state == ST_IDLE) && is_start(cntl_in)) begin
          word_count <= CNT_W'(1);
        end else if (word_count != {CNT_W{1'b1}}) begin
          word_count <= word_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_std_lane_elastic_bank.sv
// tb/tb_std_lane_elastic_bank.sv - self-checking bench for std_lane_elastic_bank
module tb_std_lane_elastic_bank;
  import std_lane_pkg::*;

  localparam int NL = 4;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NL-1:0]     lane_enable;
  logic [NL-1:0]     in_valid;
  logic [2*NL-1:0]   in_cntl;
  logic [DW*NL-1:0]  in_data;
  logic [NL-1:0]     in_ready;
  logic [NL-1:0]     out_valid;
  logic [2*NL-1:0]   out_cntl;
  logic [DW*NL-1:0]  out_data;
  logic [NL-1:0]     out_ready;
  logic              op_complete;
  logic [CW*NL-1:0]  op_word_count;
  logic [NL-1:0]     proto_err;
  logic              clear_err;

  always #5 clk = ~clk;

  std_lane_elastic_bank #(
    .NUM_LANES (NL),
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .CNT_W     (CW)
  ) dut (
    .clk             (clk),
    .reset_poweron_n (rst_n),
    .lane_enable     (lane_enable),
    .in_valid        (in_valid),
    .in_cntl         (in_cntl),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_cntl        (out_cntl),
    .out_data        (out_data),
    .out_ready       (out_ready),
    .op_complete     (op_complete),
    .op_word_count   (op_word_count),
    .proto_err       (proto_err),
    .clear_err       (clear_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: words waiting to be offered, words buffered, lane phase
  // (0 idle, 1 in operation, 2 done), active mask, counts, errors, pending pulse
  logic [33:0]   send_q [NL][$];
  logic [33:0]   mq [NL][$];
  int            mst [NL];
  int            mcnt [NL];
  logic [NL-1:0] macc;
  logic [NL-1:0] merr;
  logic          mopc;
  int            vprob = 100;
  int            rprob = 100;
  int            opc_pulses = 0;
  logic [NL-1:0] ready_seen;
  logic          clr_drv = 1'b0;

  typedef struct {
    bit         has_w;
    logic [1:0] cntl;
    bit         clr;
    bit         exp_err;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      send_q[l].delete();
      mq[l].delete();
      mst[l]  = 0;
      mcnt[l] = 0;
    end
    macc = '0;
    merr = '0;
    mopc = 1'b0;
  endtask

  // Compare this cycle's outputs with the model, then advance the model past the next edge
  task automatic model_cycle();
    logic cond;
    logic exp_opc;
    logic all_idle;
    logic exp_rdy;
    logic exp_ov;
    logic seterr;
    logic [33:0] w;
    exp_opc = mopc;
    check("op_complete", op_complete, exp_opc);
    if (op_complete) opc_pulses++;
    ready_seen |= in_ready;
    cond = (macc != 0);
    all_idle = 1'b1;
    for (int l = 0; l < NL; l++) begin
      if (macc[l] && !(mst[l] == 2 && mq[l].size() == 0)) cond = 1'b0;
      if (mst[l] != 0) all_idle = 1'b0;
    end
    for (int l = 0; l < NL; l++) begin
      exp_rdy = macc[l] && (mq[l].size() < DEPTH) && (mst[l] != 2);
      exp_ov  = macc[l] && (mq[l].size() > 0);
      check($sformatf("in_ready[%0d]", l), in_ready[l], exp_rdy);
      check($sformatf("out_valid[%0d]", l), out_valid[l], exp_ov);
      if (exp_ov) check($sformatf("out_word[%0d]", l), {out_cntl[2*l +: 2], out_data[DW*l +: DW]}, mq[l][0]);
      check($sformatf("word_count[%0d]", l), op_word_count[CW*l +: CW], mcnt[l]);
      check($sformatf("proto_err[%0d]", l), proto_err[l], merr[l]);
      if (exp_ov && out_ready[l]) void'(mq[l].pop_front());
      seterr = 1'b0;
      if (in_valid[l] && exp_rdy) begin
        w = send_q[l].pop_front();
        mq[l].push_back(w);
        if (mst[l] == 0) begin
          if (w[33:32] == 2'b00) begin mst[l] = 1; mcnt[l] = 1; end
          else if (w[33:32] == 2'b11) begin mst[l] = 2; mcnt[l] = 1; end
          else begin seterr = 1'b1; if (mcnt[l] < 65535) mcnt[l]++; end
        end else begin
          if (mcnt[l] < 65535) mcnt[l]++;
          if (w[33:32] == 2'b10) mst[l] = 2;
          if (w[33:32] == 2'b00 || w[33:32] == 2'b11) seterr = 1'b1;
        end
      end
      merr[l] = seterr | (merr[l] & ~clear_err);
      if (exp_opc && mst[l] == 2) mst[l] = 0;
    end
    if (all_idle) macc = lane_enable;
    mopc = cond && !exp_opc;
  endtask

  // One clock: drive from the offer queues, sample mid-cycle, advance to just after the edge
  task automatic step();
    logic [NL-1:0] v;
    logic [NL-1:0] r;
    for (int l = 0; l < NL; l++) begin
      v[l] = (send_q[l].size() > 0) && ($urandom_range(99) < vprob);
      in_cntl[2*l +: 2]   = v[l] ? send_q[l][0][33:32] : 2'b00;
      in_data[DW*l +: DW] = v[l] ? send_q[l][0][31:0] : '0;
      r[l] = ($urandom_range(99) < rprob);
    end
    in_valid  = v;
    out_ready = r;
    clear_err = clr_drv;
    #4;
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_quiet();
    logic q;
    q = 1'b1;
    for (int l = 0; l < NL; l++) begin
      if (send_q[l].size() != 0 || mq[l].size() != 0 || mst[l] != 0) q = 1'b0;
    end
    return q;
  endfunction

  task automatic run_until_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!model_quiet() && n < budget) begin
      step();
      n++;
    end
    check({name, "_done_in_budget"}, n < budget, 1'b1);
  endtask

  task automatic send_frame(input int l, input int len, input int seed);
    if (len == 1) begin
      send_q[l].push_back({2'b11, 32'(seed)});
    end else begin
      send_q[l].push_back({2'b00, 32'(seed)});
      for (int k = 1; k < len - 1; k++) send_q[l].push_back({2'b01, 32'(seed + k)});
      send_q[l].push_back({2'b10, 32'(seed + len - 1)});
    end
  endtask

  task automatic set_mask(input logic [NL-1:0] m);
    lane_enable = m;
    step();
    step();
  endtask

  initial begin
    vt[0] = '{1, 2'b01, 0, 1};
    vt[1] = '{0, 2'b00, 0, 1};
    vt[2] = '{0, 2'b00, 1, 0};
    vt[3] = '{1, 2'b10, 1, 1};
    vt[4] = '{0, 2'b00, 1, 0};
    vt[5] = '{1, 2'b00, 0, 0};
    vt[6] = '{1, 2'b00, 0, 1};
    vt[7] = '{0, 2'b00, 1, 0};
    vt[8] = '{1, 2'b01, 0, 0};
    vt[9] = '{1, 2'b10, 0, 0};

    rst_n = 1'b0;
    lane_enable = '0;
    in_valid = '0;
    in_cntl = '0;
    in_data = '0;
    out_ready = '0;
    clear_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_op_complete", op_complete, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_out_data_zero", out_data == 0, 1);
    check("rst_out_cntl", out_cntl, 0);
    check("rst_word_count", op_word_count, 0);
    rst_n = 1'b1;

    // All four lanes: SOD, 3 MOD, EOD with free-flowing output
    set_mask(4'b1111);
    for (int l = 0; l < NL; l++) send_frame(l, 5, 32'h100 * (l + 1));
    opc_pulses = 0;
    run_until_idle("four_lane", 100);
    check("four_lane_pulses", opc_pulses, 1);
    for (int l = 0; l < NL; l++) check($sformatf("four_lane_count[%0d]", l), op_word_count[CW*l +: CW], 5);

    // Masked lanes 1 and 3 stay closed
    set_mask(4'b0101);
    ready_seen = '0;
    send_frame(0, 1, 32'h500);
    send_frame(2, 3, 32'h600);
    opc_pulses = 0;
    run_until_idle("mask_0101", 100);
    check("mask_0101_pulses", opc_pulses, 1);
    check("mask_0101_lane1_ready", ready_seen[1], 0);
    check("mask_0101_lane3_ready", ready_seen[3], 0);
    check("mask_0101_count0", op_word_count[0 +: CW], 1);
    check("mask_0101_count2", op_word_count[2*CW +: CW], 3);

    // Backpressure: 9 words into a depth-8 lane with output stalled
    set_mask(4'b0001);
    rprob = 0;
    send_frame(0, 9, 32'h700);
    for (int n = 0; n < 30 && send_q[0].size() > 1; n++) step();
    step();
    step();
    check("full_in_ready_low", in_ready[0], 0);
    check("full_one_word_held", send_q[0].size(), 1);
    rprob = 100;
    opc_pulses = 0;
    run_until_idle("full_drain", 100);
    check("full_pulses", opc_pulses, 1);
    check("full_count", op_word_count[0 +: CW], 9);

    // Table-driven framing error / clear sequence on lane 1
    set_mask(4'b0010);
    for (int k = 0; k < 10; k++) begin
      if (vt[k].has_w) send_q[1].push_back({vt[k].cntl, 32'(32'h800 + k)});
      clr_drv = vt[k].clr;
      step();
      clr_drv = 1'b0;
      check($sformatf("vec%0d_proto_err1", k), proto_err[1], vt[k].exp_err);
    end
    run_until_idle("vec_tail", 100);
    check("vec_count1", op_word_count[CW +: CW], 4);

    // Mask change during an operation is held off until every lane is IDLE
    set_mask(4'b0001);
    send_q[0].push_back({2'b00, 32'h900});
    send_q[0].push_back({2'b01, 32'h901});
    repeat (3) step();
    lane_enable = 4'b1111;
    repeat (3) step();
    check("mask_mid_op_lane2_closed", in_ready[2], 0);
    send_q[0].push_back({2'b10, 32'h902});
    run_until_idle("mask_mid_op", 100);
    step();
    check("mask_after_op_lane2_open", in_ready[2], 1);

    // Randomized operations against the model
    for (int op = 0; op < 6; op++) begin
      set_mask(4'($urandom_range(1, 15)));
      vprob = 70;
      rprob = 60;
      for (int l = 0; l < NL; l++) begin
        if (lane_enable[l]) send_frame(l, $urandom_range(1, 12), $urandom);
      end
      opc_pulses = 0;
      run_until_idle($sformatf("rand%0d", op), 600);
      check($sformatf("rand%0d_pulses", op), opc_pulses, 1);
    end
    vprob = 100;
    rprob = 100;

    // Reset in the middle of an operation
    set_mask(4'b1111);
    rprob = 0;
    for (int l = 0; l < NL; l++) send_frame(l, 6, 32'hA00 + l);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data_zero", out_data == 0, 1);
    check("midrst_word_count", op_word_count, 0);
    check("midrst_op_complete", op_complete, 0);
    model_reset();
    in_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step();
    check("midrst_fifo_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/std_lane_elastic_bank.md
# std_lane_elastic_bank

Parametrised N-lane elastic buffer between the PE array lane outputs and the downstream stack bus. Each lane carries a framed stream (SOD/MOD/EOD); the block buffers every lane in its own FIFO, tracks framing per lane, flags protocol errors and pulses a single operation-complete event once every enabled lane has delivered and drained its end-of-data word. It generalises the fixed single-lane PE-to-stack-bus path to configurable lane count, width and depth, with lane masking and completion detection.

## Interface
- NUM_LANES, 32: number of lanes.
- DATA_W, 32: lane data width.
- DEPTH, 8: per-lane FIFO depth (power of two, >= 2).
- CNT_W, 16: per-lane word-count width.
- clk  in  1  clock.
- reset_poweron_n  in  1  asynchronous, active-low reset.
- lane_enable  in  NUM_LANES  lane mask, sampled only while all lanes are IDLE.
- in_valid  in  NUM_LANES  per-lane input valid.
- in_cntl  in  2*NUM_LANES  per-lane framing: 00 SOD, 01 MOD, 10 EOD, 11 SOD_EOD.
- in_data  in  DATA_W*NUM_LANES  per-lane data.
- in_ready  out  NUM_LANES  per-lane input ready.
- out_valid  out  NUM_LANES  per-lane output valid.
- out_cntl  out  2*NUM_LANES  buffered framing.
- out_data  out  DATA_W*NUM_LANES  buffered data.
- out_ready  in  NUM_LANES  downstream ready.
- op_complete  out  1  one-cycle completion pulse.
- op_word_count  out  CNT_W*NUM_LANES  words accepted per lane in the last operation.
- proto_err  out  NUM_LANES  sticky framing error per lane.
- clear_err  in  1  clears all proto_err bits.

## Operation
- Transfer on a side occurs when valid && ready in the same cycle.
- Active mask: a register loaded from lane_enable on every cycle in which all lanes are IDLE; frozen otherwise. Reset value 0.
- Per-lane input FSM: IDLE, IN_OP, DONE.
  - IDLE: SOD -> IN_OP; SOD_EOD -> DONE; MOD/EOD -> stay IDLE, set proto_err.
  - IN_OP: MOD -> stay; EOD -> DONE; SOD/SOD_EOD -> stay IN_OP, set proto_err.
  - DONE: no input accepted; returns to IDLE in the cycle after op_complete.
- Erroneous words are still written to the FIFO; the error is reported, not filtered.
- in_ready[i] = active[i] && !full[i] && state[i] != DONE. Inactive lanes never assert in_ready or out_valid.
- Word count: cleared on accepted SOD/SOD_EOD in IDLE and then counts that word; increments on every accepted word; saturates at 2^CNT_W-1. op_word_count holds its value until the next SOD on that lane.
- op_complete: asserted for one cycle when at least one lane is active and every active lane is DONE with an empty FIFO. All DONE lanes go to IDLE on the following edge.
- proto_err is sticky. clear_err clears it. A new error in the same cycle as clear_err wins, leaving the bit set.

## Timing
- Reset: in_ready, out_valid, op_complete and proto_err are 0. out_cntl, out_data and op_word_count are 0. FIFOs are empty, FSMs are IDLE and the mask is 0.
- Latency: a word accepted at edge N is visible on out_valid after edge N, i.e. one cycle later. There is no combinational in-to-out path.
- Full FIFO: in_ready is low; a pop in the same cycle re-opens in_ready the next cycle only (ready is registered from the count).
- Simultaneous push and pop when not full or empty: the occupancy is unchanged.
- Pointers wrap modulo DEPTH. Occupancy width is $clog2(DEPTH+1).
- Reset asserted mid-operation drops all buffered data and counts immediately.

## Structure
- Package std_lane_pkg holds:
  - the cntl encoding enum (SOD, MOD, EOD, SOD_EOD);
  - the lane state enum (IDLE, IN_OP, DONE);
  - the width constants.
- Sub-module std_lane_fifo: a single-lane synchronous FIFO with occupancy, instantiated once per lane in a generate loop.
- FSMs, counters and completion logic live in the top module.

## Test plan
- NUM_LANES=4, mask 1111, each lane sends SOD, 3×MOD, EOD with out_ready=1 -> each lane outputs 5 words in order; op_complete pulses once, one cycle after the last EOD pops; op_word_count=5 per lane.
- Mask 0101, lane 0 sends SOD_EOD, lane 2 sends SOD,MOD,EOD -> lanes 1 and 3 keep in_ready=0; op_complete pulses; counts are 1 and 3.
- out_ready=0, lane 0 pushes 9 words with DEPTH=8 -> in_ready drops after 8 accepts; release out_ready -> all 9 words emerge in order, with no loss or duplication.
- Lane 1 sends MOD while IDLE -> proto_err[1]=1 and persists; clear_err -> 0; error and clear_err in the same cycle -> remains 1.
- Mask changed mid-op -> ignored until all lanes are IDLE. Reset asserted mid-op -> all outputs go to 0 immediately, and the FIFOs are empty after release.
